// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// mode/state encodings and the address window used by the core's decode.
package mips_timer_pkg;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;
    localparam logic [1:0] TIMER_RSVD   = 2'd3;

    localparam logic [31:0] TIMER_ADDR_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER_ADDR_LAST = 32'h0000_7F0B;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01
    } timer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Only the exact 01 encoding reloads; 1x falls back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the timer: one tick every 2^PS cycles, PS clamped to 7.
// Used only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic       clk_I,
    input  logic       rst_I,
    input  logic       clr_I,
    input  logic [3:0] ps_I,
    output logic       tick_O
);

    logic [7:0] cnt_r;
    logic [2:0] ps_eff_s;
    logic [7:0] mask_s;

    // Clamp the prescale exponent and form the low-bit mask that marks a tick
    always_comb begin
        ps_eff_s = ps_I[3] ? 3'd7 : ps_I[2:0];
        mask_s   = (8'd1 << ps_eff_s) - 8'd1;
        tick_O   = ((cnt_r & mask_s) == mask_s);
    end

    // Free-running counter, restarted whenever the timer reloads
    always_ff @(posedge clk_I) begin
        if (!rst_I) begin
            cnt_r <= 8'd0;
        end else if (clr_I) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and
// auto-reload modes. Optional prescaler enabled by defining TIMER_PRESCALE_EN.
import mips_timer_pkg::*;

module mips_timer #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk_I,
    input  logic        rst_I,
    input  logic [1:0]  addr_I,
    input  logic        we_I,
    input  logic [3:0]  be_I,
    input  logic [31:0] din_I,
    output logic [31:0] dout_O,
    output logic        irq_O
);

    timer_state_e state_r, state_s;
    logic         en_r, en_w_s, en_s;
    logic [1:0]   mode_r, mode_s;
    logic         im_r, im_s;
    logic [31:0]  preset_r, preset_s;
    logic [31:0]  count_r, count_s;
    logic         irq_r, irq_s;
    logic         ctrl_wr_s;
    logic [3:0]   ctrl_lo_s;
    logic         load_s;
    logic         enter_int_s;
    logic         tick_s;
    logic [3:0]   ps_rd_s;

`ifdef TIMER_PRESCALE_EN
    logic [3:0]   ps_r, ps_s;

    timer_prescaler u_prescaler (
        .clk_I  (clk_I),
        .rst_I  (rst_I),
        .clr_I  (load_s),
        .ps_I   (ps_r),
        .tick_O (tick_s)
    );

    assign ps_rd_s = ps_r;

    // PS lives in the CTRL low byte alongside EN/MODE/IM
    always_comb begin
        ps_s = (ctrl_wr_s && be_I[0]) ? din_I[7:4] : ps_r;
    end
`else
    assign tick_s  = 1'b1;
    assign ps_rd_s = 4'd0;
`endif

    // Register write decode with per-lane byte enables
    always_comb begin
        ctrl_wr_s = we_I && (addr_I == TIMER_CTRL);
        ctrl_lo_s = be_I[0] ? din_I[3:0] : {im_r, mode_r, en_r};
        if (ctrl_wr_s) begin
            en_w_s = ctrl_lo_s[0];
            mode_s = ctrl_lo_s[2:1];
            im_s   = ctrl_lo_s[3];
        end else begin
            en_w_s = en_r;
            mode_s = mode_r;
            im_s   = im_r;
        end
        if (we_I && (addr_I == TIMER_PRESET)) begin
            preset_s = merge_bytes(preset_r, din_I, be_I);
        end else begin
            preset_s = preset_r;
        end
    end

    // Next-state and counter logic; a disabling CTRL write beats every other event
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        load_s  = 1'b0;
        if (ctrl_wr_s && !en_w_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = en_r ? ST_LOAD : ST_IDLE;
                end
                ST_LOAD: begin
                    count_s = preset_r;
                    load_s  = 1'b1;
                    state_s = ST_CNT;
                end
                ST_CNT: begin
                    if (count_r == 32'd0) begin
                        state_s = ST_INT;
                    end else if (tick_s) begin
                        if (count_r == 32'd1) begin
                            count_s = 32'd0;
                            state_s = ST_INT;
                        end else begin
                            count_s = count_r - 32'd1;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_INT: begin
                    state_s = (ctrl_wr_s || is_reload(mode_r)) ? ST_LOAD : ST_INT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        // One-shot expiry drops EN so software sees the timer has stopped
        enter_int_s = (state_s == ST_INT) && (state_r != ST_INT);
        en_s        = (enter_int_s && !is_reload(mode_s)) ? 1'b0 : en_w_s;
        irq_s       = (state_s == ST_INT) && im_s;
    end

    // State, register file and interrupt flop
    always_ff @(posedge clk_I) begin
        if (!rst_I) begin
            state_r  <= ST_IDLE;
            en_r     <= 1'b0;
            mode_r   <= 2'b00;
            im_r     <= 1'b0;
            preset_r <= PRESET_RST;
            count_r  <= 32'd0;
            irq_r    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps_r     <= 4'd0;
`endif
        end else begin
            state_r  <= state_s;
            en_r     <= en_s;
            mode_r   <= mode_s;
            im_r     <= im_s;
            preset_r <= preset_s;
            count_r  <= count_s;
            irq_r    <= irq_s;
`ifdef TIMER_PRESCALE_EN
            ps_r     <= ps_s;
`endif
        end
    end

    // Read mux, combinational from the word select
    always_comb begin
        case (addr_I)
            TIMER_CTRL:   dout_O = {24'd0, ps_rd_s, im_r, mode_r, en_r};
            TIMER_PRESET: dout_O = preset_r;
            TIMER_COUNT:  dout_O = count_r;
            default:      dout_O = 32'd0;
        endcase
    end

    assign irq_O = irq_r;

endmodule

// File: tb/tb_mips_timer.sv
// Scoreboard bench for mips_timer: expectations are queued as stimulus is
// applied and popped when the corresponding output is sampled.
module tb_mips_timer;
    import mips_timer_pkg::*;

    localparam logic [31:0] PRST = 32'hDEAD_0005;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    mips_timer #(.PRESET_RST(PRST)) dut (
        .clk_I  (clk),
        .rst_I  (rst),
        .addr_I (addr),
        .we_I   (we),
        .be_I   (be),
        .din_I  (din),
        .dout_O (dout),
        .irq_O  (irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        e = sb_q.pop_front();
        check_value(e.tag, obs, e.val);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; din = d; we = 1'b1;
        cycle();
        we = 1'b0; be = 4'd0; din = 32'd0;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        sb_push(tag, v);
        addr = a;
        #1;
        sb_pop_check(dout);
    endtask

    task automatic expect_irq(input string tag, input logic v);
        sb_push(tag, {31'd0, v});
        sb_pop_check({31'd0, irq});
    endtask

    initial begin
        int p;
        // Reset held for two edges
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        expect_reg("rst_ctrl", TIMER_CTRL, 32'd0);
        expect_reg("rst_preset", TIMER_PRESET, PRST);
        expect_reg("rst_count", TIMER_COUNT, 32'd0);
        expect_irq("rst_irq", 1'b0);

        // One-shot, N=5: counts 5..0 then irq held
        wr(TIMER_PRESET, 4'hF, 32'd5);
        wr(TIMER_CTRL, 4'hF, 32'h9);
        cycle();
        expect_irq("m0_irq_load", 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            expect_reg("m0_count", TIMER_COUNT, 32'(5 - k));
            expect_irq("m0_irq", k == 5);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            expect_irq("m0_irq_held", 1'b1);
        end
        expect_reg("m0_ctrl_en_clr", TIMER_CTRL, 32'h8);
        wr(TIMER_CTRL, 4'hF, 32'h0);
        expect_irq("m0_irq_clr", 1'b0);

        // Auto-reload, N=3: one-cycle pulses every 5 cycles
        wr(TIMER_PRESET, 4'hF, 32'd3);
        wr(TIMER_CTRL, 4'hF, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            cycle();
            expect_irq("m1_irq", (k % 5) == 0);
        end
        expect_reg("m1_ctrl_en_kept", TIMER_CTRL, 32'hB);

        // Auto-reload with IM=0: COUNT cycles 3,2,1,0,0 and irq stays low
        wr(TIMER_CTRL, 4'hF, 32'h0);
        wr(TIMER_CTRL, 4'hF, 32'h3);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            expect_irq("m1_masked_irq", 1'b0);
            if (k >= 2) begin
                p = (k - 2) % 5;
                expect_reg("m1_masked_count", TIMER_COUNT, (p < 3) ? 32'(3 - p) : 32'd0);
            end
        end

        // Disable in the expiring-tick cycle: IDLE, no irq, COUNT holds 1
        wr(TIMER_CTRL, 4'hF, 32'h0);
        wr(TIMER_PRESET, 4'hF, 32'd2);
        wr(TIMER_CTRL, 4'hF, 32'h9);
        cycle();
        cycle();
        cycle();
        expect_reg("race_pre_count", TIMER_COUNT, 32'd1);
        wr(TIMER_CTRL, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            expect_irq("race_irq", 1'b0);
            expect_reg("race_count", TIMER_COUNT, 32'd1);
            cycle();
        end
        expect_reg("race_ctrl", TIMER_CTRL, 32'h0);

        // Byte lanes, read-only COUNT, reserved word
        wr(TIMER_PRESET, 4'hF, 32'h1122_3344);
        wr(TIMER_PRESET, 4'b0010, 32'hAAAA_AAAA);
        expect_reg("byte_preset", TIMER_PRESET, 32'h1122_AA44);
        wr(TIMER_COUNT, 4'hF, 32'hFFFF_FFFF);
        expect_reg("count_ro", TIMER_COUNT, 32'd1);
        wr(TIMER_RSVD, 4'hF, 32'hFFFF_FFFF);
        expect_reg("rsvd_read", TIMER_RSVD, 32'd0);

        // PRESET written during LOAD: LOAD takes the old value
        wr(TIMER_PRESET, 4'hF, 32'd4);
        wr(TIMER_CTRL, 4'hF, 32'h9);
        cycle();
        wr(TIMER_PRESET, 4'hF, 32'd7);
        expect_reg("load_old_preset", TIMER_COUNT, 32'd4);
        wr(TIMER_CTRL, 4'hF, 32'h0);
        expect_reg("stop_count_hold", TIMER_COUNT, 32'd4);
        expect_reg("new_preset", TIMER_PRESET, 32'd7);

        // Reset mid-count
        wr(TIMER_PRESET, 4'hF, 32'd10);
        wr(TIMER_CTRL, 4'hF, 32'h9);
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        expect_reg("rst_mid_count", TIMER_COUNT, 32'd0);
        expect_reg("rst_mid_ctrl", TIMER_CTRL, 32'd0);
        expect_reg("rst_mid_preset", TIMER_PRESET, PRST);
        expect_irq("rst_mid_irq", 1'b0);

        // Reset while in INT drops irq on the sampled edge
        wr(TIMER_PRESET, 4'hF, 32'd1);
        wr(TIMER_CTRL, 4'hF, 32'h9);
        for (int k = 0; k < 4; k++) cycle();
        expect_irq("int_irq_before_rst", 1'b1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        expect_irq("int_irq_after_rst", 1'b0);
        expect_reg("int_count_after_rst", TIMER_COUNT, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // PS=2: COUNT steps every 4 cycles
        wr(TIMER_PRESET, 4'hF, 32'd2);
        wr(TIMER_CTRL, 4'hF, 32'h29);
        cycle();
        for (int k = 2; k <= 10; k++) begin
            cycle();
            expect_reg("ps_count", TIMER_COUNT, (k < 6) ? 32'd2 : ((k < 10) ? 32'd1 : 32'd0));
        end
        expect_irq("ps_irq", 1'b1);
        expect_reg("ps_ctrl", TIMER_CTRL, 32'h28);
`endif

        check_value("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
